// File: rtl/motoro3_step_pwm_if.sv
`timescale 1ns/1ps
// Register-block side of the six-step PWM driver: run/config values in,
// commutation status and the six gate-driver lines out.
interface motoro3_step_pwm_if;
  logic        m3_run;
  logic [24:0] m3reg_step_cnt_reload1;
  logic [7:0]  m3reg_power_percent;
  logic [11:0] pwmLenWant;
  logic [11:0] pwmMinMask;

  logic [2:0]  m3_step_idx;
  logic        m3_step_strobe;
  logic        pwm_period_start;
  logic [11:0] pwm_duty_now;
  logic [2:0]  m3_gate_hi;
  logic [2:0]  m3_gate_lo;

  modport master (
    output m3_run, m3reg_step_cnt_reload1, m3reg_power_percent, pwmLenWant, pwmMinMask,
    input  m3_step_idx, m3_step_strobe, pwm_period_start, pwm_duty_now, m3_gate_hi, m3_gate_lo
  );

  modport slave (
    input  m3_run, m3reg_step_cnt_reload1, m3reg_power_percent, pwmLenWant, pwmMinMask,
    output m3_step_idx, m3_step_strobe, pwm_period_start, pwm_duty_now, m3_gate_hi, m3_gate_lo
  );
endinterface

// File: rtl/motoro3_step_pwm.sv
`timescale 1ns/1ps
// Six-step commutation driver: step timer, PWM carrier, serial len*pct/DIV_CONST
// duty engine and dead-time-protected gate decode for three half-bridges.
module motoro3_step_pwm #(
  parameter int DEAD_CYC  = 8,
  parameter int DIV_CONST = 100
) (
  input  logic              clk,
  input  logic              nRst,
  motoro3_step_pwm_if.slave bus
);

  localparam int            DW      = (DEAD_CYC < 1) ? 1 : $clog2(DEAD_CYC + 1);
  localparam logic [DW-1:0] DEAD_LD = DW'(DEAD_CYC);
  localparam logic [20:0]   DIVISOR = 21'(DIV_CONST);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} duty_st_e;

  logic          run_q;
  logic [24:0]   step_cnt_q, step_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          strobe_q, strobe_d;
  logic [DW-1:0] dead_q, dead_d;

  logic [11:0]   pwm_cnt_q, pwm_cnt_d;
  logic [11:0]   len_q, len_d;
  logic [11:0]   duty_q, duty_d;

  duty_st_e      st_q, st_d;
  logic [19:0]   acc_q, acc_d;     // product during MUL, quotient during DIV
  logic [19:0]   mcand_q, mcand_d;
  logic [7:0]    mplier_q, mplier_d;
  logic [19:0]   rem_q, rem_d;
  logic [4:0]    it_q, it_d;
  logic [11:0]   mask_q, mask_d;

  logic [24:0]   reload;
  logic          active, start, pstart, len_ok, pwm_on, gate_en;
  logic [11:0]   len_eff, clamp;
  logic [20:0]   trial;
  logic [2:0]    tbl_hi, tbl_lo;

  assign reload = bus.m3reg_step_cnt_reload1;
  assign active = run_q & bus.m3_run;
  assign start  = bus.m3_run & ~run_q;

  // At count 0 the new period's length is being latched, so it governs this cycle.
  assign len_eff = (pwm_cnt_q == 12'd0) ? bus.pwmLenWant : len_q;
  assign len_ok  = (len_eff >= 12'd2);
  assign pstart  = active & (pwm_cnt_q == 12'd0);
  assign pwm_on  = len_ok & (pwm_cnt_q < duty_q);

  // Step timer and dead-time counter
  always_comb begin
    step_cnt_d = step_cnt_q;
    idx_d      = idx_q;
    strobe_d   = 1'b0;
    dead_d     = dead_q;
    if (start) begin
      step_cnt_d = (reload == '0) ? '0 : reload - 25'd1;
      dead_d     = DEAD_LD;
    end else if (active) begin
      if (reload != '0 && step_cnt_q == '0) begin
        step_cnt_d = reload - 25'd1;
        idx_d      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        strobe_d   = 1'b1;
        dead_d     = DEAD_LD;
      end else begin
        if (reload != '0) step_cnt_d = step_cnt_q - 25'd1;
        if (dead_q != '0) dead_d = dead_q - DW'(1);
      end
    end
  end

  // PWM carrier
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    len_d     = len_q;
    if (active) begin
      if (pstart) len_d = bus.pwmLenWant;
      if (!len_ok || pwm_cnt_q >= len_eff - 12'd1) pwm_cnt_d = 12'd0;
      else                                         pwm_cnt_d = pwm_cnt_q + 12'd1;
    end
  end

  // Clamp the finished quotient: over-range, then minimum on-time, then minimum off-time.
  always_comb begin
    clamp = acc_q[11:0];
    if (acc_q > {8'd0, len_q})                 clamp = len_q;
    else if (acc_q < {8'd0, mask_q})           clamp = 12'd0;
    else if ((len_q - acc_q[11:0]) < mask_q)   clamp = len_q;
  end

  // Duty engine: every period start restarts from freshly latched inputs.
  always_comb begin
    st_d     = st_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    it_d     = it_q;
    mask_d   = mask_q;
    duty_d   = duty_q;
    trial    = {rem_q, acc_q[19]};
    if (active) begin
      if (pstart) begin
        if (st_q == DONE) duty_d = clamp;
        mcand_d  = {8'd0, bus.pwmLenWant};
        mplier_d = bus.m3reg_power_percent;
        mask_d   = bus.pwmMinMask;
        acc_d    = '0;
        it_d     = '0;
        st_d     = MUL;
      end else begin
        case (st_q)
          MUL: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            it_d     = it_q + 5'd1;
            if (it_q == 5'd7) begin
              it_d  = '0;
              rem_d = '0;
              st_d  = DIV;
            end
          end
          DIV: begin
            if (trial >= DIVISOR) begin
              rem_d = 20'(trial - DIVISOR);
              acc_d = {acc_q[18:0], 1'b1};
            end else begin
              rem_d = trial[19:0];
              acc_d = {acc_q[18:0], 1'b0};
            end
            it_d = it_q + 5'd1;
            if (it_q == 5'd19) st_d = DONE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      run_q      <= 1'b0;
      step_cnt_q <= '0;
      idx_q      <= '0;
      strobe_q   <= 1'b0;
      dead_q     <= DEAD_LD;
      pwm_cnt_q  <= '0;
      len_q      <= '0;
      duty_q     <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      it_q       <= '0;
      mask_q     <= '0;
    end else begin
      run_q      <= bus.m3_run;
      step_cnt_q <= step_cnt_d;
      idx_q      <= idx_d;
      strobe_q   <= strobe_d;
      dead_q     <= dead_d;
      pwm_cnt_q  <= pwm_cnt_d;
      len_q      <= len_d;
      duty_q     <= duty_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      it_q       <= it_d;
      mask_q     <= mask_d;
    end
  end

  // Commutation table: one hi phase and a different lo phase per step.
  always_comb begin
    tbl_hi = 3'b000;
    tbl_lo = 3'b000;
    case (idx_q)
      3'd0: begin tbl_hi = 3'b001; tbl_lo = 3'b010; end
      3'd1: begin tbl_hi = 3'b001; tbl_lo = 3'b100; end
      3'd2: begin tbl_hi = 3'b010; tbl_lo = 3'b100; end
      3'd3: begin tbl_hi = 3'b010; tbl_lo = 3'b001; end
      3'd4: begin tbl_hi = 3'b100; tbl_lo = 3'b001; end
      3'd5: begin tbl_hi = 3'b100; tbl_lo = 3'b010; end
      default: ;
    endcase
  end

  assign gate_en              = run_q & (dead_q == '0);
  assign bus.m3_gate_hi       = (gate_en & pwm_on) ? tbl_hi : 3'b000;
  assign bus.m3_gate_lo       = gate_en ? tbl_lo : 3'b000;
  assign bus.m3_step_idx      = idx_q;
  assign bus.m3_step_strobe   = strobe_q;
  assign bus.pwm_period_start = pstart;
  assign bus.pwm_duty_now     = duty_q;

endmodule

// File: tb/tb_motoro3_step_pwm.sv
`timescale 1ns/1ps
// Directed bench for motoro3_step_pwm: duty arithmetic and clamps, step sequencing,
// dead time, degenerate settings, reset mid-computation and run control.
module tb_motoro3_step_pwm;
  logic clk = 1'b0;
  logic nRst;
  int   checks = 0;
  int   errors = 0;
  int   shoot  = 0;

  motoro3_step_pwm_if bus();

  motoro3_step_pwm #(.DEAD_CYC(8), .DIV_CONST(100)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #50 clk = ~clk;

  // Same-phase hi/lo overlap is never allowed.
  always @(negedge clk)
    if (nRst === 1'b1 && (bus.m3_gate_hi & bus.m3_gate_lo) != 3'b000) shoot++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pstart(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (bus.pwm_period_start !== 1'b1 && n < 5000);
    checks++;
    if (bus.pwm_period_start !== 1'b1) begin
      errors++; $display("FAIL %s: no period start within %0d cycles", tag, n);
    end
  endtask

  task automatic wait_strobe(input string tag, input int limit, output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while (bus.m3_step_strobe !== 1'b1 && n < limit);
    if (bus.m3_step_strobe !== 1'b1) begin
      errors++; $display("FAIL %s: no step strobe within %0d cycles", tag, n);
    end
  endtask

  task automatic count_hi(output int on);
    on = 0;
    for (int i = 0; i < 512; i++) begin
      if (bus.m3_gate_hi != 3'b000) on++;
      tick(1);
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    bus.m3_run = 1'b1;
    bus.m3reg_step_cnt_reload1 = 25'd16667;
    bus.m3reg_power_percent = 8'd16;
    bus.pwmLenWant = 12'd512;
    bus.pwmMinMask = 12'd32;
    tick(3);
    checks++;
    if ({bus.m3_gate_hi, bus.m3_gate_lo} !== 6'd0) begin
      errors++; $display("FAIL reset_gates: got %b/%b want 000/000", bus.m3_gate_hi, bus.m3_gate_lo);
    end
    checks++;
    if (bus.m3_step_idx !== 3'd0 || bus.m3_step_strobe !== 1'b0) begin
      errors++; $display("FAIL reset_step: idx %0d strobe %b want 0/0", bus.m3_step_idx, bus.m3_step_strobe);
    end
    checks++;
    if (bus.pwm_period_start !== 1'b0 || bus.pwm_duty_now !== 12'd0) begin
      errors++; $display("FAIL reset_pwm: pstart %b duty %0d want 0/0", bus.pwm_period_start, bus.pwm_duty_now);
    end
    nRst = 1'b1;
  endtask

  task automatic test_nominal();
    int on;
    wait_pstart("nom_p1");
    tick(1);
    checks++;
    if (bus.pwm_duty_now !== 12'd0) begin
      errors++; $display("FAIL nom_duty_p1: got %0d want 0", bus.pwm_duty_now);
    end
    wait_pstart("nom_p2");
    tick(1);
    checks++;
    if (bus.pwm_duty_now !== 12'd81) begin
      errors++; $display("FAIL nom_duty_p2: got %0d want 81", bus.pwm_duty_now);
    end
    wait_pstart("nom_p3");
    checks++;
    if (bus.m3_gate_lo !== 3'b010) begin
      errors++; $display("FAIL nom_lo: got %b want 010", bus.m3_gate_lo);
    end
    count_hi(on);
    checks++;
    if (on != 81) begin
      errors++; $display("FAIL nom_hi_count: got %0d want 81", on);
    end
  endtask

  task automatic test_duty_clamp();
    int pct [4];
    int exp [4];
    int on;
    pct = '{5, 95, 255, 50};
    exp = '{0, 512, 512, 256};
    for (int k = 0; k < 4; k++) begin
      bus.m3reg_power_percent = 8'(pct[k]);
      wait_pstart("clamp_a");
      wait_pstart("clamp_b");
      wait_pstart("clamp_c");
      tick(1);
      checks++;
      if (bus.pwm_duty_now !== 12'(exp[k])) begin
        errors++; $display("FAIL clamp_duty pct=%0d: got %0d want %0d", pct[k], bus.pwm_duty_now, exp[k]);
      end
      count_hi(on);
      checks++;
      if (on != exp[k]) begin
        errors++; $display("FAIL clamp_hi_count pct=%0d: got %0d want %0d", pct[k], on, exp[k]);
      end
    end
    bus.m3reg_power_percent = 8'd16;
  endtask

  task automatic test_step_sequence();
    logic [2:0] e_idx [6];
    logic [2:0] e_hi  [6];
    logic [2:0] e_lo  [6];
    int n, off, bad;
    e_idx = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    e_hi  = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    e_lo  = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b010};
    nRst = 1'b0;
    bus.m3reg_step_cnt_reload1 = 25'd1000;
    tick(2);
    nRst = 1'b1;
    wait_strobe("step_first", 2000, n);
    checks++;
    if (n != 1001) begin
      errors++; $display("FAIL step_first_len: got %0d want 1001", n);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bus.m3_step_idx !== e_idx[k]) begin
        errors++; $display("FAIL step_idx k=%0d: got %0d want %0d", k, bus.m3_step_idx, e_idx[k]);
      end
      off = 0;
      for (int j = 0; j < 8; j++) begin
        if ({bus.m3_gate_hi, bus.m3_gate_lo} != 6'd0) off++;
        tick(1);
      end
      checks++;
      if (off != 0) begin
        errors++; $display("FAIL step_dead k=%0d: %0d driven cycles want 0", k, off);
      end
      checks++;
      if (bus.m3_gate_lo !== e_lo[k]) begin
        errors++; $display("FAIL step_lo k=%0d: got %b want %b", k, bus.m3_gate_lo, e_lo[k]);
      end
      bad = 0;
      for (int j = 0; j < 500; j++) begin
        if ((bus.m3_gate_hi & ~e_hi[k]) != 3'b000 || bus.m3_gate_lo !== e_lo[k]) bad++;
        tick(1);
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL step_table k=%0d: %0d bad cycles want 0", k, bad);
      end
      wait_strobe("step_next", 2000, n);
      checks++;
      if (n + 508 != 1000) begin
        errors++; $display("FAIL step_len k=%0d: got %0d want 1000", k, n + 508);
      end
    end
  endtask

  task automatic test_reload_change();
    int n1, n2;
    tick(100);
    bus.m3reg_step_cnt_reload1 = 25'd500;
    wait_strobe("reload_cur", 2000, n1);
    checks++;
    if (n1 + 100 != 1000) begin
      errors++; $display("FAIL reload_cur_len: got %0d want 1000", n1 + 100);
    end
    wait_strobe("reload_next", 2000, n2);
    checks++;
    if (n2 != 500) begin
      errors++; $display("FAIL reload_next_len: got %0d want 500", n2);
    end
  endtask

  task automatic test_reload_zero();
    logic [2:0] idx0;
    int strobes;
    tick(10);
    bus.m3reg_step_cnt_reload1 = 25'd0;
    idx0 = bus.m3_step_idx;
    strobes = 0;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (bus.m3_step_strobe === 1'b1) strobes++;
    end
    checks++;
    if (strobes != 0 || bus.m3_step_idx !== idx0) begin
      errors++; $display("FAIL reload_zero: strobes %0d idx %0d want 0 and idx %0d", strobes, bus.m3_step_idx, idx0);
    end
  endtask

  task automatic test_len_one();
    int hi_on, no_ps;
    bus.pwmLenWant = 12'd1;
    tick(600);
    hi_on = 0;
    no_ps = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.m3_gate_hi != 3'b000) hi_on++;
      if (bus.pwm_period_start !== 1'b1) no_ps++;
      tick(1);
    end
    checks++;
    if (hi_on != 0) begin
      errors++; $display("FAIL len1_hi: %0d hi cycles want 0", hi_on);
    end
    checks++;
    if (no_ps != 0) begin
      errors++; $display("FAIL len1_pstart: %0d cycles without period start want 0", no_ps);
    end
    checks++;
    if (bus.pwm_duty_now !== 12'd81) begin
      errors++; $display("FAIL len1_duty_hold: got %0d want 81", bus.pwm_duty_now);
    end
    bus.pwmLenWant = 12'd512;
    bus.m3reg_step_cnt_reload1 = 25'd1000;
  endtask

  task automatic test_reset_mid();
    int off;
    wait_pstart("mid_p");
    tick(15);
    #10 nRst = 1'b0;
    #1;
    checks++;
    if ({bus.m3_gate_hi, bus.m3_gate_lo, bus.m3_step_idx} !== 9'd0) begin
      errors++; $display("FAIL mid_async_gates: hi %b lo %b idx %0d want 0", bus.m3_gate_hi, bus.m3_gate_lo, bus.m3_step_idx);
    end
    checks++;
    if (bus.pwm_duty_now !== 12'd0 || bus.m3_step_strobe !== 1'b0 || bus.pwm_period_start !== 1'b0) begin
      errors++; $display("FAIL mid_async_pwm: duty %0d strobe %b pstart %b want 0", bus.pwm_duty_now, bus.m3_step_strobe, bus.pwm_period_start);
    end
    @(negedge clk);
    nRst = 1'b1;
    tick(1);
    checks++;
    if (bus.m3_step_idx !== 3'd0) begin
      errors++; $display("FAIL mid_idx: got %0d want 0", bus.m3_step_idx);
    end
    off = 0;
    for (int j = 0; j < 8; j++) begin
      if ({bus.m3_gate_hi, bus.m3_gate_lo} != 6'd0) off++;
      tick(1);
    end
    checks++;
    if (off != 0) begin
      errors++; $display("FAIL mid_dead: %0d driven cycles want 0", off);
    end
    checks++;
    if (bus.m3_gate_lo !== 3'b010 || bus.pwm_duty_now !== 12'd0) begin
      errors++; $display("FAIL mid_after_dead: lo %b duty %0d want 010/0", bus.m3_gate_lo, bus.pwm_duty_now);
    end
    wait_pstart("mid_p2");
    checks++;
    if (bus.pwm_duty_now !== 12'd0) begin
      errors++; $display("FAIL mid_duty_pre: got %0d want 0", bus.pwm_duty_now);
    end
    tick(1);
    checks++;
    if (bus.pwm_duty_now !== 12'd81) begin
      errors++; $display("FAIL mid_duty_post: got %0d want 81", bus.pwm_duty_now);
    end
  endtask

  task automatic test_run_drop();
    checks++;
    if (bus.m3_gate_lo !== 3'b010) begin
      errors++; $display("FAIL run_before: lo %b want 010", bus.m3_gate_lo);
    end
    bus.m3_run = 1'b0;
    tick(1);
    checks++;
    if ({bus.m3_gate_hi, bus.m3_gate_lo} !== 6'd0 || bus.pwm_period_start !== 1'b0) begin
      errors++; $display("FAIL run_drop: hi %b lo %b pstart %b want 0", bus.m3_gate_hi, bus.m3_gate_lo, bus.pwm_period_start);
    end
    checks++;
    if (bus.pwm_duty_now !== 12'd81) begin
      errors++; $display("FAIL run_hold_duty: got %0d want 81", bus.pwm_duty_now);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_duty_clamp();
    test_step_sequence();
    test_reload_change();
    test_reload_zero();
    test_len_one();
    test_reset_mid();
    test_run_drop();
    checks++;
    if (shoot != 0) begin
      errors++; $display("FAIL shoot_through: %0d overlap cycles want 0", shoot);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
